// File: rtl/led_pkg.sv
// Shared types, default WS2812 timing and the GRB reorder helper for the LED strip transmitter.
package led_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    BIT_HI,
    BIT_LO,
    LATCH
  } tx_state_t;

  localparam int DEF_N_LED = 78;
  localparam int DEF_T0H   = 59;
  localparam int DEF_T1H   = 119;
  localparam int DEF_TBIT  = 186;
  localparam int DEF_TRST  = 11880;

  // WS2812 expects green first on the wire
  function automatic logic [23:0] rgb_to_grb(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

endpackage

// File: rtl/led_zone_pingpong.sv
// Two-bank zone buffer: the capture side always writes the bank the transmitter is not reading.
module led_zone_pingpong
  import led_pkg::*;
#(
  parameter int N_LED = DEF_N_LED
) (
  input  logic                                      clkn,
  input  logic                                      resetn,
  input  logic                                      dv,
  input  logic [23:0]                               wr_data,
  input  logic                                      accept,
  input  logic [((N_LED > 1) ? $clog2(N_LED) : 1)-1:0] rd_idx,
  output logic [23:0]                               rd_data,
  output logic                                      start,
  output logic                                      frame_drop
);

  localparam int LW = (N_LED > 1) ? $clog2(N_LED) : 1;
  localparam int WW = $clog2(N_LED + 2);
  localparam logic [WW-1:0] FULL = WW'(N_LED);
  localparam logic [WW-1:0] OVER = WW'(N_LED + 1);

  logic [23:0]   mem [2][N_LED];
  logic          wr_bank;
  logic          pending;
  logic          dv_d;
  logic [WW-1:0] wr_idx;
  logic          burst_end;
  logic          complete;

  assign burst_end = dv_d && !dv;
  assign complete  = burst_end && (wr_idx == FULL);
  // A hand-over is refused while a burst is still writing, so the banks never collide
  assign start     = accept && !dv && (pending || complete);
  assign rd_data   = mem[~wr_bank][rd_idx];

  always_ff @(negedge clkn) begin
    if (!resetn && dv && (wr_idx < FULL))
      mem[wr_bank][wr_idx[LW-1:0]] <= wr_data;
  end

  always_ff @(negedge clkn) begin
    if (resetn) begin
      wr_idx     <= '0;
      dv_d       <= 1'b0;
      wr_bank    <= 1'b0;
      pending    <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      dv_d       <= dv;
      frame_drop <= 1'b0;
      if (!dv)
        wr_idx <= '0;
      else if (wr_idx != OVER)
        wr_idx <= wr_idx + WW'(1);

      if (start) begin
        wr_bank    <= ~wr_bank;
        pending    <= 1'b0;
        frame_drop <= complete && pending;
      end else if (complete) begin
        pending    <= 1'b1;
        frame_drop <= pending;
      end else if (burst_end) begin
        // A short or long burst has scribbled over the write bank, so nothing there is sendable
        pending    <= 1'b0;
        frame_drop <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_strip_down_tx.sv
// WS2812 strip transmitter fed by per-zone colour bursts on the falling edge of clkn.
// Optional macro LED_DIM_EN halves every colour channel before transmission.
module led_strip_down_tx
  import led_pkg::*;
#(
  parameter int N_LED = DEF_N_LED,
  parameter int T0H   = DEF_T0H,
  parameter int T1H   = DEF_T1H,
  parameter int TBIT  = DEF_TBIT,
  parameter int TRST  = DEF_TRST
) (
  input  logic        clkn,
  input  logic        resetn,
  input  logic        dv_RGB_hor_up_in,
  input  logic [23:0] RGB_hor_up_in,
  output logic        led_dout,
  output logic        busy,
  output logic        frame_drop
);

  localparam int CW = $clog2(TRST + 1);
  localparam int LW = (N_LED > 1) ? $clog2(N_LED) : 1;
  localparam logic [CW-1:0] T0H_C   = CW'(T0H);
  localparam logic [CW-1:0] T1H_C   = CW'(T1H);
  localparam logic [CW-1:0] TBIT_M1 = CW'(TBIT - 1);
  localparam logic [CW-1:0] TRST_M1 = CW'(TRST - 1);
  localparam logic [LW-1:0] LAST_LED = LW'(N_LED - 1);

  tx_state_t     state;
  logic [CW-1:0] cnt;
  logic [LW-1:0] led_idx;
  logic [4:0]    bit_idx;
  logic [23:0]   shreg;
  logic [23:0]   rd_data;
  logic [23:0]   load_word;
  logic [CW-1:0] th_cur;
  logic [CW-1:0] th_load;
  logic          accept;
  logic          start;

  assign accept  = (state == IDLE) || ((state == LATCH) && (cnt == TRST_M1));
  assign th_cur  = shreg[23] ? T1H_C : T0H_C;
  assign th_load = load_word[23] ? T1H_C : T0H_C;

  always_comb begin
    load_word = rgb_to_grb(rd_data);
`ifdef LED_DIM_EN
    load_word = {1'b0, load_word[23:17], 1'b0, load_word[15:9], 1'b0, load_word[7:1]};
`endif
  end

  led_zone_pingpong #(.N_LED(N_LED)) u_buf (
    .clkn       (clkn),
    .resetn     (resetn),
    .dv         (dv_RGB_hor_up_in),
    .wr_data    (RGB_hor_up_in),
    .accept     (accept),
    .rd_idx     (led_idx),
    .rd_data    (rd_data),
    .start      (start),
    .frame_drop (frame_drop)
  );

  // LOAD is also the first high cycle of bit 0, so fetching a word costs no line time
  always_ff @(negedge clkn) begin
    if (resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      led_idx  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      led_dout <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE, LATCH: begin
          if (start) begin
            state    <= LOAD;
            cnt      <= '0;
            led_idx  <= '0;
            bit_idx  <= '0;
            led_dout <= 1'b1;
            busy     <= 1'b1;
          end else if ((state == LATCH) && (cnt != TRST_M1)) begin
            cnt <= cnt + CW'(1);
          end else begin
            state    <= IDLE;
            cnt      <= '0;
            led_dout <= 1'b0;
            busy     <= 1'b0;
          end
        end
        LOAD: begin
          shreg <= load_word;
          cnt   <= CW'(1);
          if (th_load > CW'(1)) begin
            state    <= BIT_HI;
            led_dout <= 1'b1;
          end else begin
            state    <= BIT_LO;
            led_dout <= 1'b0;
          end
        end
        BIT_HI: begin
          cnt <= cnt + CW'(1);
          if ((cnt + CW'(1)) >= th_cur) begin
            state    <= BIT_LO;
            led_dout <= 1'b0;
          end
        end
        BIT_LO: begin
          if (cnt == TBIT_M1) begin
            cnt <= '0;
            if (bit_idx == 5'd23) begin
              bit_idx <= '0;
              if (led_idx == LAST_LED) begin
                state    <= LATCH;
                led_dout <= 1'b0;
              end else begin
                led_idx  <= led_idx + LW'(1);
                state    <= LOAD;
                led_dout <= 1'b1;
              end
            end else begin
              bit_idx  <= bit_idx + 5'd1;
              shreg    <= {shreg[22:0], 1'b0};
              state    <= BIT_HI;
              led_dout <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
